// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types, opcodes and helpers for the ALU sequencer.
// Optional statistics are enabled by defining ALU_SEQ_STATS_EN.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      SHIFT = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADC = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_SBC = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_ROL = 4'b1010;
   localparam logic [3:0] OP_ROR = 4'b1011;

   function automatic logic is_shift(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

   function automatic logic is_arith(input logic [3:0] op);
      return op[3:2] == 2'b00;
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op[3:2] == 2'b11;
   endfunction

endpackage

// File: rtl/alu_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Grants the first request at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int PW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant
);

   logic w_found;
   int   w_idx;

   // scan from the pointer and pick the first active request
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (int'(i_ptr) + k) % NREQ;
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one combinational ALU among requesters.
// Define ALU_SEQ_STATS_EN to add perf_ops / perf_busy counters.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 8,
   localparam int PW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
   input  logic [3*NREQ-1:0] req_sc,
   output logic [3:0]        alu_op,
   output logic [W-1:0]      alu_a,
   output logic [W-1:0]      alu_b,
   output logic              alu_cin,
   output logic [2:0]        alu_sc,
   input  logic [W-1:0]      alu_y,
   input  logic              alu_cout,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [PW-1:0]     rsp_id,
   output logic [W-1:0]      rsp_y,
   output logic              rsp_cout,
   output logic              rsp_zero,
   output logic              rsp_err
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0]       perf_ops,
   output logic [15:0]       perf_busy
`endif
);

   state_t r_state, w_nstate;

   logic [PW-1:0]   r_ptr, r_id;
   logic [3:0]      r_op;
   logic [W-1:0]    r_acc, r_b;
   logic            r_cin;
   logic [2:0]      r_cnt;
   logic [W-1:0]    r_rsp_y;
   logic            r_rsp_cout, r_rsp_zero, r_rsp_err;

   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_gid, w_ptr_nxt;
   logic [3:0]      w_op_in;
   logic [W-1:0]    w_a_in, w_b_in;
   logic            w_cin_in;
   logic [2:0]      w_sc_in;
   logic            w_accept;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   // select the granted requester's operands
   always_comb begin
      w_gid     = '0;
      w_ptr_nxt = '0;
      w_op_in   = '0;
      w_a_in    = '0;
      w_b_in    = '0;
      w_cin_in  = 1'b0;
      w_sc_in   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_gid     = PW'(i);
            w_ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            w_op_in   = req_op[4*i +: 4];
            w_a_in    = req_a[W*i +: W];
            w_b_in    = req_b[W*i +: W];
            w_cin_in  = req_cin[i];
            w_sc_in   = req_sc[3*i +: 3];
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nstate;
   end

   // next state, request accept and ALU drive
   always_comb begin
      w_nstate  = r_state;
      w_accept  = 1'b0;
      req_ready = '0;
      alu_op    = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_cin   = 1'b0;
      alu_sc    = '0;
      unique case (r_state)
         IDLE: begin
            if (rst_n) begin
               req_ready = w_grant;
               if (|w_grant) begin
                  w_accept = 1'b1;
                  w_nstate = (is_shift(w_op_in) && w_sc_in != 3'd0)
                           ? SHIFT : EXEC;
               end
            end
         end
         EXEC: begin
            alu_op   = r_op;
            alu_a    = r_acc;
            alu_b    = r_b;
            alu_cin  = r_cin;
            w_nstate = RESP;
         end
         SHIFT: begin
            alu_op = r_op;
            alu_a  = r_acc;
            alu_sc = 3'd1;
            if (r_cnt == 3'd1) w_nstate = RESP;
         end
         RESP: begin
            if (rsp_ready) w_nstate = IDLE;
         end
      endcase
   end

   // operand latch, shift accumulator and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_id       <= '0;
         r_op       <= '0;
         r_acc      <= '0;
         r_b        <= '0;
         r_cin      <= 1'b0;
         r_cnt      <= '0;
         r_rsp_y    <= '0;
         r_rsp_cout <= 1'b0;
         r_rsp_zero <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op  <= w_op_in;
                  r_acc <= w_a_in;
                  r_b   <= w_b_in;
                  r_cin <= w_cin_in;
                  r_cnt <= w_sc_in;
                  r_id  <= w_gid;
                  r_ptr <= w_ptr_nxt;
               end
            end
            EXEC: begin
               if (is_illegal(r_op)) begin
                  r_rsp_y    <= '0;
                  r_rsp_zero <= 1'b1;
                  r_rsp_cout <= 1'b0;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_rsp_y    <= alu_y;
                  r_rsp_zero <= alu_zero;
                  r_rsp_cout <= is_arith(r_op) ? alu_cout : 1'b0;
                  r_rsp_err  <= 1'b0;
               end
            end
            SHIFT: begin
               r_acc <= alu_y;
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  r_rsp_y    <= alu_y;
                  r_rsp_zero <= alu_zero;
                  r_rsp_cout <= 1'b0;
                  r_rsp_err  <= 1'b0;
               end
            end
            RESP: begin
            end
         endcase
      end
   end

   assign rsp_valid = (r_state == RESP);
   assign rsp_id    = r_id;
   assign rsp_y     = r_rsp_y;
   assign rsp_cout  = r_rsp_cout;
   assign rsp_zero  = r_rsp_zero;
   assign rsp_err   = r_rsp_err;

`ifdef ALU_SEQ_STATS_EN
   logic [15:0] r_perf_ops, r_perf_busy;

   // saturating completed-response and busy-cycle counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_ops  <= '0;
         r_perf_busy <= '0;
      end else begin
         if (rsp_valid && rsp_ready && r_perf_ops != 16'hFFFF)
            r_perf_ops <= r_perf_ops + 16'd1;
         if (r_state != IDLE && r_perf_busy != 16'hFFFF)
            r_perf_busy <= r_perf_busy + 16'd1;
      end
   end

   assign perf_ops  = r_perf_ops;
   assign perf_busy = r_perf_busy;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer.
// Includes a small reference ALU feeding the DUT's ALU port.
module tb_alu_sequencer;

   localparam int NREQ = 2;
   localparam int W    = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [7:0]      req_op = '0;
   logic [15:0]     req_a = '0;
   logic [15:0]     req_b = '0;
   logic [1:0]      req_cin = '0;
   logic [5:0]      req_sc = '0;
   logic [3:0]      alu_op;
   logic [7:0]      alu_a, alu_b;
   logic            alu_cin;
   logic [2:0]      alu_sc;
   logic [7:0]      alu_y;
   logic            alu_cout, alu_zero;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [0:0]      rsp_id;
   logic [7:0]      rsp_y;
   logic            rsp_cout, rsp_zero, rsp_err;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0]     perf_ops, perf_busy;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu_sequencer #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_sc    (req_sc),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_cin   (alu_cin),
      .alu_sc    (alu_sc),
      .alu_y     (alu_y),
      .alu_cout  (alu_cout),
      .alu_zero  (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_cout  (rsp_cout),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err)
`ifdef ALU_SEQ_STATS_EN
      ,
      .perf_ops  (perf_ops),
      .perf_busy (perf_busy)
`endif
   );

   always #5 clk = ~clk;

   // reference ALU; garbage y/cout on ops where the sequencer must mask them
   logic [15:0] t_rot;
   always_comb begin
      alu_y    = alu_a ^ 8'hA5;
      alu_cout = 1'b1;
      t_rot    = {alu_a, alu_a};
      case (alu_op)
         4'd0: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
         4'd1: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b}
                                 + {8'd0, alu_cin};
         4'd2: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
         4'd3: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b}
                                 + {8'd0, alu_cin};
         4'd4: alu_y = alu_a & alu_b;
         4'd5: alu_y = alu_a | alu_b;
         4'd6: alu_y = alu_a ^ alu_b;
         4'd7: alu_y = ~(alu_a | alu_b);
         4'd8: alu_y = alu_a << alu_sc;
         4'd9: alu_y = alu_a >> alu_sc;
         4'd10: begin
            t_rot = {alu_a, alu_a} << alu_sc;
            alu_y = t_rot[15:8];
         end
         4'd11: begin
            t_rot = {alu_a, alu_a} >> alu_sc;
            alu_y = t_rot[7:0];
         end
         default: ;
      endcase
      alu_zero = (alu_y == 8'd0);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a request and wait (bounded) for it to be accepted
   task automatic issue(input int r, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [2:0] sc,
                        output logic ok);
      int g;
      req_op[4*r +: 4] = op;
      req_a[8*r +: 8]  = a;
      req_b[8*r +: 8]  = b;
      req_cin[r]       = cin;
      req_sc[3*r +: 3] = sc;
      req_valid[r]     = 1'b1;
      #1;
      g = 0;
      while (!req_ready[r] && g < 20) begin
         tick();
         g++;
      end
      ok = req_ready[r];
      tick();
      req_valid[r] = 1'b0;
   endtask

   // full transaction: accept, latency, result, response handshake
   task automatic run_op(input string tag, input int r,
                         input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin,
                         input logic [2:0] sc, input logic [7:0] ey,
                         input logic ec, input logic ez, input logic ee,
                         input int elat, input int escn);
      logic ok;
      int   lat, scn;
      issue(r, op, a, b, cin, sc, ok);
      chk({tag, "_acc"}, 32'(ok), 1);
      lat = 1;
      scn = 0;
      while (!rsp_valid && lat < 20) begin
         if (alu_sc == 3'd1 && alu_op == op) scn++;
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_scn"}, scn, escn);
      chk({tag, "_id"}, 32'(rsp_id), r);
      chk({tag, "_y"}, 32'(rsp_y), 32'(ey));
      chk({tag, "_c"}, 32'(rsp_cout), 32'(ec));
      chk({tag, "_z"}, 32'(rsp_zero), 32'(ez));
      chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_done"}, 32'(rsp_valid), 0);
   endtask

   initial begin
      logic ok;
      int   g, hits;

      // reset, with requests pending: nothing may be accepted
      rst_n     = 1'b0;
      req_valid = 2'b11;
      tick();
      tick();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_y", 32'(rsp_y), 0);
      chk("rst_alu_a", 32'(alu_a), 0);
      req_valid = 2'b00;
      rst_n     = 1'b1;
      tick();

      run_op("add", 0, 4'd0, 8'd200, 8'd100, 1'b0, 3'd0,
             8'd44, 1'b1, 1'b0, 1'b0, 2, 0);
      run_op("adc", 0, 4'd1, 8'hFF, 8'h00, 1'b1, 3'd0,
             8'h00, 1'b1, 1'b1, 1'b0, 2, 0);
      run_op("shl3", 1, 4'd8, 8'h81, 8'h00, 1'b0, 3'd3,
             8'h08, 1'b0, 1'b0, 1'b0, 4, 3);
      run_op("rol1", 1, 4'd10, 8'h81, 8'h00, 1'b0, 3'd1,
             8'h03, 1'b0, 1'b0, 1'b0, 2, 1);

      // both requesters continuously valid: grants alternate
      req_op    = {4'd2, 4'd2};
      req_a     = {8'd5, 8'd5};
      req_b     = {8'd5, 8'd5};
      req_cin   = '0;
      req_sc    = '0;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         g = 0;
         while (!rsp_valid && g < 20) begin
            tick();
            g++;
         end
         chk("alt_id", 32'(rsp_id), n % 2);
         chk("alt_y", 32'(rsp_y), 0);
         chk("alt_z", 32'(rsp_zero), 1);
         if (n > 0) chk("alt_gap", g + 1, 3);
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      tick();

      // response back-pressure with another requester waiting
      issue(0, 4'd6, 8'h3C, 8'h0F, 1'b0, 3'd0, ok);
      chk("bp_acc", 32'(ok), 1);
      g = 0;
      while (!rsp_valid && g < 20) begin
         tick();
         g++;
      end
      req_op[7:4]  = 4'd4;
      req_a[15:8]  = 8'hF0;
      req_b[15:8]  = 8'h3C;
      req_valid[1] = 1'b1;
      #1;
      for (int n = 0; n < 5; n++) begin
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_y", 32'(rsp_y), 32'h33);
         chk("bp_c", 32'(rsp_cout), 0);
         chk("bp_ready", 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_rel_valid", 32'(rsp_valid), 0);
      chk("bp_rel_grant", 32'(req_ready), 32'b10);
      tick();
      req_valid[1] = 1'b0;
      g = 0;
      while (!rsp_valid && g < 20) begin
         tick();
         g++;
      end
      chk("bp2_id", 32'(rsp_id), 1);
      chk("bp2_y", 32'(rsp_y), 32'h30);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      run_op("illegal", 0, 4'd13, 8'h12, 8'h34, 1'b0, 3'd0,
             8'h00, 1'b0, 1'b1, 1'b1, 2, 0);
      run_op("shr0", 0, 4'd9, 8'h5A, 8'h00, 1'b0, 3'd0,
             8'h5A, 1'b0, 1'b0, 1'b0, 2, 0);
      run_op("shr2", 1, 4'd9, 8'h03, 8'h00, 1'b0, 3'd2,
             8'h00, 1'b0, 1'b1, 1'b0, 3, 2);
      run_op("ror4", 1, 4'd11, 8'h01, 8'h00, 1'b0, 3'd4,
             8'h10, 1'b0, 1'b0, 1'b0, 5, 4);

      // reset in the middle of a shift abandons it
      issue(0, 4'd8, 8'h81, 8'h00, 1'b0, 3'd3, ok);
      chk("ab_acc", 32'(ok), 1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("ab_valid", 32'(rsp_valid), 0);
      chk("ab_alu_sc", 32'(alu_sc), 0);
      chk("ab_rsp_y", 32'(rsp_y), 0);
      req_valid = 2'b11;
      #1;
      chk("ab_ptr", 32'(req_ready), 32'b01);
      req_valid = 2'b00;
      hits = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (rsp_valid) hits++;
      end
      chk("ab_stale", hits, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
